// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg
//   Shared definitions for the PC redirect controller:
//   - the PC source mux select encoding,
//   - the controller state encoding,
//   - a helper that maps the redirecting instruction's kind onto a mux select.
package pc_redirect_ctrl_pkg;

    // PC source mux inputs: sequential, branch/JAL target, JALR target, held target
    typedef enum logic [1:0] {
        PC_SEL_SEQ  = 2'd0,
        PC_SEL_BR   = 2'd1,
        PC_SEL_JALR = 2'd2,
        PC_SEL_HELD = 2'd3
    } pc_sel_e;

    // Controller states; 2'd3 is unused and recovers to BOOT
    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } ctrl_state_e;

    // JALR outranks JAL and taken branches; JAL and branch share the PC+imm input
    function automatic pc_sel_e redirect_sel(input logic is_jalr);
        pc_sel_e sel;
        if (is_jalr) begin
            sel = PC_SEL_JALR;
        end else begin
            sel = PC_SEL_BR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// sat_counter
//   Saturating up-counter; sticks at all-ones and never wraps.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

    logic [W-1:0] count_r;

    // Count register: clear on reset, increment unless already saturated
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Controls the PC source mux (0=PC+4, 1=branch/JAL target, 2=JALR target,
//   3=held target). Resolves EX-stage control transfers, flushes wrong-path
//   instructions and defers a redirect while fetch is stalled. Owns the
//   held-target register: reset vector at boot, or the deferred target.
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   if_stall                : fetch cannot accept a new PC this cycle
//   ex_valid/branch/taken/jal/jalr : EX-stage instruction qualifiers
//   ex_br_target            : PC+imm from EX
//   ex_jalr_target          : (rs1+imm)&~1 from EX
//   pc_sel, pc_write        : PC mux select and PC load enable
//   held_target             : mux input 3
//   flush_if_id, flush_id_ex: pipeline squash controls
//   redirect_cnt            : saturating count of redirects taken
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stall,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_taken,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic [XLEN-1:0]  ex_br_target,
    input  logic [XLEN-1:0]  ex_jalr_target,
    output logic [1:0]       pc_sel,
    output logic             pc_write,
    output logic [XLEN-1:0]  held_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] redirect_cnt
);

    ctrl_state_e     state_r;
    ctrl_state_e     next_state_s;
    logic [XLEN-1:0] held_target_r;
    logic            redir_s;
    logic [XLEN-1:0] target_s;
    logic            capture_s;
    logic            inc_s;

    assign redir_s  = ex_valid & (ex_jalr | ex_jal | (ex_branch & ex_taken));
    assign target_s = ex_jalr ? ex_jalr_target : ex_br_target;

    // State register; reset always returns to BOOT
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Held target: reset vector on reset, EX target when a redirect is deferred
    always_ff @(posedge clk) begin
        if (rst) begin
            held_target_r <= RESET_VEC;
        end else if (capture_s) begin
            held_target_r <= target_s;
        end else begin
            held_target_r <= held_target_r;
        end
    end

    // Next-state and output decode
    always_comb begin
        next_state_s = state_r;
        pc_sel       = PC_SEL_SEQ;
        pc_write     = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        capture_s    = 1'b0;
        inc_s        = 1'b0;
        if (rst) begin
            // Everything quiet while reset is held; a deferred target is dropped
            next_state_s = ST_BOOT;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    // Fetch from the reset vector; nothing in the pipe is real yet
                    pc_sel      = PC_SEL_HELD;
                    pc_write    = ~if_stall;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (!if_stall) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_BOOT;
                    end
                end
                ST_RUN: begin
                    if (redir_s && !if_stall) begin
                        // Redirect lands on this edge
                        pc_sel      = redirect_sel(ex_jalr);
                        pc_write    = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        inc_s       = 1'b1;
                    end else if (redir_s) begin
                        // Fetch frozen: park the target and replay it later
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        capture_s    = 1'b1;
                        inc_s        = 1'b1;
                        next_state_s = ST_PENDING;
                    end else begin
                        pc_sel   = PC_SEL_SEQ;
                        pc_write = ~if_stall;
                    end
                end
                ST_PENDING: begin
                    // Anything reaching EX now is wrong-path and already squashed
                    pc_sel      = PC_SEL_HELD;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (!if_stall) begin
                        pc_write     = 1'b1;
                        next_state_s = ST_RUN;
                    end else begin
                        pc_write     = 1'b0;
                        next_state_s = ST_PENDING;
                    end
                end
                default: begin
                    next_state_s = ST_BOOT;
                end
            endcase
        end
    end

    assign held_target = held_target_r;

    sat_counter #(
        .W(CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_s),
        .count (redirect_cnt)
    );

endmodule
